// File: rtl/nv_nvdla_ssync_pkg.sv
// Shared constants and elaboration-time parameter check for the
// filtered level synchronizer.
package nv_nvdla_ssync_pkg;

    localparam int SSYNC_MIN_STAGES = 2;

    function automatic bit ssync_params_ok(input int width, input int stages, input int filt_w);
        return (stages >= SSYNC_MIN_STAGES) && (width >= 1) && (filt_w >= 1);
    endfunction

endpackage

// File: rtl/nv_nvdla_ssync_filt_ch.sv
// One channel: async level -> flop chain -> glitch filter -> level + strobes.
// chg_nxt is the pre-register change flag, so the top can register chg_o
// alongside the strobes.
module nv_nvdla_ssync_filt_ch #(
    parameter int   STAGES  = 3,
    parameter int   FILT_W  = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic              o_clk,
    input  logic              o_rst,
    input  logic              async_i,
    input  logic [FILT_W-1:0] filt_thresh,
    input  logic              test_mode,
    output logic              sync_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              chg_nxt
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    logic [STAGES-2:0] chain;
    logic              raw;
    logic [FILT_W-1:0] cnt;
    logic [FILT_W-1:0] cnt_nxt;
    logic              level_nxt;
    logic              flip;

    assign raw     = chain[STAGES-2];
    assign chg_nxt = flip;

    // Flip once raw has disagreed for more than filt_thresh cycles; >= keeps a
    // lowered threshold from stalling or wrapping a count already past it.
    always_comb begin
        cnt_nxt   = '0;
        level_nxt = sync_o;
        flip      = 1'b0;
        if (test_mode) begin
            level_nxt = raw;
            flip      = (raw != sync_o);
        end else if (raw != sync_o) begin
            if (cnt >= filt_thresh) begin
                level_nxt = raw;
                flip      = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge o_clk) begin
        if (o_rst) begin
            meta   <= RST_VAL;
            chain  <= {(STAGES-1){RST_VAL}};
            sync_o <= RST_VAL;
            cnt    <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            meta     <= async_i;
            chain[0] <= meta;
            for (int s = 1; s < STAGES - 1; s++) begin
                chain[s] <= chain[s-1];
            end
            sync_o <= level_nxt;
            cnt    <= cnt_nxt;
            rise_o <= flip & level_nxt;
            fall_o <= flip & ~level_nxt;
        end
    end

endmodule

// File: rtl/nv_nvdla_ssync_filt.sv
// Multi-channel filtered level synchronizer: WIDTH independent channels plus
// a registered any-change flag.
module nv_nvdla_ssync_filt
    import nv_nvdla_ssync_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               STAGES  = 3,
    parameter int               FILT_W  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              o_clk,
    input  logic              o_rst,
    input  logic [WIDTH-1:0]  async_i,
    input  logic [FILT_W-1:0] filt_thresh,
    input  logic              test_mode,
    output logic [WIDTH-1:0]  sync_o,
    output logic [WIDTH-1:0]  rise_o,
    output logic [WIDTH-1:0]  fall_o,
    output logic              chg_o
);

    if (!ssync_params_ok(WIDTH, STAGES, FILT_W)) begin : g_param_err
        $error("nv_nvdla_ssync_filt: need STAGES>=2, WIDTH>=1, FILT_W>=1");
    end

    logic [WIDTH-1:0] chg_nxt;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        nv_nvdla_ssync_filt_ch #(
            .STAGES  (STAGES),
            .FILT_W  (FILT_W),
            .RST_VAL (RST_VAL[g])
        ) u_ch (
            .o_clk       (o_clk),
            .o_rst       (o_rst),
            .async_i     (async_i[g]),
            .filt_thresh (filt_thresh),
            .test_mode   (test_mode),
            .sync_o      (sync_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g]),
            .chg_nxt     (chg_nxt[g])
        );
    end

    always_ff @(posedge o_clk) begin
        if (o_rst) begin
            chg_o <= 1'b0;
        end else begin
            chg_o <= |chg_nxt;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_ssync_filt.sv
// Scoreboard bench: a history-based reference model pushes the expected
// outputs for every edge; a monitor pops and compares after each edge.
module tb_nv_nvdla_ssync_filt;

    localparam int               WIDTH   = 4;
    localparam int               STAGES  = 3;
    localparam int               FILT_W  = 4;
    localparam logic [WIDTH-1:0] RST_VAL = '0;

    logic              o_clk = 1'b0;
    logic              o_rst = 1'b1;
    logic [WIDTH-1:0]  async_i = 4'hF;
    logic [FILT_W-1:0] filt_thresh = 4'd2;
    logic              test_mode = 1'b0;
    logic [WIDTH-1:0]  sync_o;
    logic [WIDTH-1:0]  rise_o;
    logic [WIDTH-1:0]  fall_o;
    logic              chg_o;

    always #5 o_clk = ~o_clk;

    nv_nvdla_ssync_filt #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .FILT_W  (FILT_W),
        .RST_VAL (RST_VAL)
    ) dut (
        .o_clk       (o_clk),
        .o_rst       (o_rst),
        .async_i     (async_i),
        .filt_thresh (filt_thresh),
        .test_mode   (test_mode),
        .sync_o      (sync_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .chg_o       (chg_o)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sync;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
        logic             chg;
    } exp_t;

    exp_t             expq[$];
    logic [WIDTH-1:0] capq[$];   // async values captured at the last STAGES edges
    logic [WIDTH-1:0] m_level;
    int               m_dis[WIDTH];
    int               n_tests = 0;
    int               n_fail  = 0;

    // Reference: raw seen at an edge is the input captured STAGES edges earlier;
    // the level follows raw once raw has disagreed for more than thresh cycles.
    always @(posedge o_clk) begin : model
        exp_t             e;
        logic [WIDTH-1:0] raw;
        e = '0;
        if (o_rst) begin
            capq.delete();
            for (int s = 0; s < STAGES; s++) capq.push_back(RST_VAL);
            m_level = RST_VAL;
            for (int i = 0; i < WIDTH; i++) m_dis[i] = 0;
        end else begin
            raw = capq[0];
            for (int i = 0; i < WIDTH; i++) begin
                if (test_mode) begin
                    if (raw[i] != m_level[i]) begin
                        e.rise[i] = raw[i];
                        e.fall[i] = ~raw[i];
                    end
                    m_level[i] = raw[i];
                    m_dis[i]   = 0;
                end else if (raw[i] == m_level[i]) begin
                    m_dis[i] = 0;
                end else if (m_dis[i] >= int'(filt_thresh)) begin
                    e.rise[i]  = raw[i];
                    e.fall[i]  = ~raw[i];
                    m_level[i] = raw[i];
                    m_dis[i]   = 0;
                end else begin
                    m_dis[i] = m_dis[i] + 1;
                end
            end
            void'(capq.pop_front());
            capq.push_back(async_i);
        end
        e.sync = m_level;
        e.chg  = |(e.rise | e.fall);
        expq.push_back(e);
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    always @(posedge o_clk) begin : monitor
        exp_t e;
        #1;
        if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard at %0t: got no expectation, expected one per edge", $time);
        end else begin
            e = expq.pop_front();
            check("sync_o", sync_o, e.sync);
            check("rise_o", rise_o, e.rise);
            check("fall_o", fall_o, e.fall);
            check("chg_o", {{(WIDTH-1){1'b0}}, chg_o}, {{(WIDTH-1){1'b0}}, e.chg});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge o_clk);
    endtask

    initial begin : driver
        int b;
        // reset with inputs high, then release and let them propagate
        cyc(2);
        o_rst = 1'b0;
        cyc(12);
        // glitch rejection at thresh=3
        async_i = 4'h0; cyc(12);
        filt_thresh = 4'd3;
        async_i[0] = 1'b1; cyc(3); async_i[0] = 1'b0; cyc(12);
        async_i[0] = 1'b1; cyc(5); async_i[0] = 1'b0; cyc(15);
        // threshold lowered while a count is in progress
        filt_thresh = 4'd10;
        async_i[1] = 1'b1; cyc(8);
        filt_thresh = 4'd2; cyc(6);
        async_i[1] = 1'b0; cyc(10);
        // bypass with maximal threshold
        test_mode = 1'b1; filt_thresh = 4'd15;
        async_i[2] = 1'b1; cyc(1); async_i[2] = 1'b0; cyc(8);
        test_mode = 1'b0; filt_thresh = 4'd1;
        // opposite simultaneous transitions on channels 0 and 3
        async_i[3] = 1'b1; cyc(10);
        async_i[0] = 1'b1; async_i[3] = 1'b0; cyc(10);
        // reset in the middle of a count
        filt_thresh = 4'd8;
        async_i[1] = 1'b1; cyc(STAGES - 1 + 5);
        o_rst = 1'b1; cyc(1);
        o_rst = 1'b0; cyc(20);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 15) begin
                b = $urandom_range(0, WIDTH - 1);
                async_i[b] = ~async_i[b];
            end
            if ($urandom_range(0, 99) < 2) filt_thresh = FILT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 199) < 2) test_mode = ~test_mode;
            o_rst = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        o_rst = 1'b0;
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_ssync_filt.md
# nv_nvdla_ssync_filt

Parametrised multi-channel level synchronizer with per-channel glitch filter and edge detection, in the destination clock domain. Each channel takes an asynchronous single-bit level (launched from a flop in a foreign domain), resynchronizes it through a configurable-depth flop chain, and suppresses pulses shorter than a programmable threshold. It outputs a clean level plus single-cycle rise/fall strobes. It is the successor to the fixed 3-stage, 1-bit strict synchronizer, used for CSB interrupt, power-request and status lines entering the core domain.

## Interface
- WIDTH, 4, number of independent channels (>=1)
- STAGES, 3, synchronizer depth in flops (>=2)
- FILT_W, 4, width of filter threshold and per-channel counter (>=1)
- RST_VAL, {WIDTH{1'b0}}, reset value of sync chain, filtered level and counters' reference level per channel
- o_clk  input  1  destination clock; single clock domain for the whole block
- o_rst  input  1  reset, synchronous, active-high
- async_i  input  WIDTH  asynchronous level inputs; no timing relationship to o_clk
- filt_thresh  input  FILT_W  quasi-static filter threshold, shared by all channels
- test_mode  input  1  1 = bypass filter (sync_o follows sync chain output directly)
- sync_o  output  WIDTH  filtered, synchronized level
- rise_o  output  WIDTH  one-cycle strobe on sync_o 0->1
- fall_o  output  WIDTH  one-cycle strobe on sync_o 1->0
- chg_o  output  1  OR of all rise_o/fall_o bits, registered alongside them

## Operation
- Sync chain: STAGES flops per bit; raw[i] = last stage. No logic between stages.
- Per-channel counter cnt[i] (FILT_W bits) counts consecutive cycles with raw[i] != sync_o[i].
- Each cycle, per channel:
  - raw == sync_o: cnt <= 0.
  - raw != sync_o and cnt >= filt_thresh: sync_o <= raw, cnt <= 0, strobe rise/fall per new value.
  - Otherwise: cnt <= cnt + 1. The counter cannot wrap because it clears at the threshold.
- Compare is >=, not ==. Lowering filt_thresh mid-count while cnt is above the new value causes a flip on the next disagreeing cycle, with no wrap and no stall.
- A glitch on raw shorter than filt_thresh+1 cycles is fully absorbed: no sync_o change and no strobe.
- test_mode=1: sync_o <= raw every cycle, cnt held at 0, strobes still generated on every change.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous strobes, and chg_o is asserted once.
- filt_thresh is sampled each cycle. Software changes it only while inputs are idle. Changing it while inputs are active is legal but counts are not guaranteed.

## Timing
- Reset (o_rst=1 at a rising edge): sync chain = RST_VAL, sync_o = RST_VAL, cnt = 0, rise_o = fall_o = 0, chg_o = 0.
- Reset mid-operation clears all state in the same edge, and in-flight counts are discarded. On reset exit no strobe is emitted merely because async_i differs from RST_VAL. That difference must pass the full chain and filter.
- Latency from an async_i change captured at edge k:
  - raw changes at edge k+STAGES-1.
  - sync_o changes at edge k+STAGES+filt_thresh.
  - With filt_thresh=0, STAGES=3: sync_o changes 3 edges after capture.
- rise_o/fall_o/chg_o are registered and high for exactly the one cycle in which sync_o first shows the new value.
- test_mode: latency = STAGES edges.
- Async capture uncertainty: ±1 cycle, inherent to the first stage.

## Structure
- Package nv_nvdla_ssync_pkg:
  - constant SSYNC_MIN_STAGES = 2.
  - function for the elaboration-time parameter check (STAGES >= 2, WIDTH >= 1, FILT_W >= 1).
- Sub-module nv_nvdla_ssync_filt_ch: one channel (chain, counter, level, strobes), generated WIDTH times.
- Top level holds the generate loop and the chg_o OR-reduce/register.
- First-stage flops carry the synchronizer attribute for CDC tools. No reset-less flops.

## Test plan
- Reset: hold o_rst 2 cycles with async_i=4'hF, RST_VAL=0 -> sync_o=0, no strobes; after release, thresh=2: sync_o=4'hF at edge STAGES+2 after release, rise_o=4'hF for 1 cycle, chg_o=1.
- Glitch reject: thresh=3, pulse async_i[0] high 3 cycles -> sync_o[0] stays 0, no strobe; pulse 5 cycles -> rise_o[0] at 3+3 edges after capture, fall_o[0] 5 cycles later.
- Threshold lowering: thresh=10, hold raw differing 6 cycles, set thresh=2 -> flip on the next cycle, cnt back to 0, no wrap.
- test_mode=1, thresh=15: 1-cycle pulse on async_i[2] -> sync_o[2] high exactly 1 cycle at edge STAGES, rise_o/fall_o on consecutive cycles.
- Simultaneous: channels 0 and 3 toggle opposite directions in the same cycle -> rise_o[0] and fall_o[3] in the same cycle, chg_o=1 for one cycle.
- Reset mid-count: thresh=8, assert o_rst at count 5 -> all outputs back to RST_VAL next edge, full re-filter after release.
